// File: rtl/layer_dense_tiled_pkg.sv
// Shared types and helpers for the tiled dense classifier layer.
package layer_dense_tiled_pkg;

  typedef enum logic [2:0] {
    StFill,
    StCompute,
    StFinish,
    StOut,
    StRtz
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/dense_top2.sv
// Running top-2 tracker: folds a tile of LANES scores into best/second/index.
// Lanes are visited in ascending class order; strict > keeps the lower index on ties.
module dense_top2 #(
  parameter int unsigned BIT_DATA = 8,
  parameter int unsigned BIT_IDX  = 4,
  parameter int unsigned LANES    = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              update,
  input  logic [BIT_IDX-1:0]                base,
  input  logic [LANES-1:0]                  valid,
  input  logic [LANES-1:0][BIT_DATA-1:0]    scores,
  output logic signed [BIT_DATA-1:0]        best,
  output logic signed [BIT_DATA-1:0]        second,
  output logic [BIT_IDX-1:0]                best_idx,
  output logic                              have_second
);

  logic signed [BIT_DATA-1:0] best_q, best_d, second_q, second_d;
  logic [BIT_IDX-1:0]         idx_q, idx_d;
  logic                       have_best_q, have_best_d, have_second_q, have_second_d;

  always_comb begin
    best_d        = best_q;
    second_d      = second_q;
    idx_d         = idx_q;
    have_best_d   = have_best_q;
    have_second_d = have_second_q;
    for (int l = 0; l < LANES; l++) begin
      if (valid[l]) begin
        if (!have_best_d || $signed(scores[l]) > best_d) begin
          if (have_best_d) begin
            second_d      = best_d;
            have_second_d = 1'b1;
          end
          best_d      = scores[l];
          idx_d       = base + BIT_IDX'(l);
          have_best_d = 1'b1;
        end else if (!have_second_d || $signed(scores[l]) > second_d) begin
          second_d      = scores[l];
          have_second_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      best_q        <= '0;
      second_q      <= '0;
      idx_q         <= '0;
      have_best_q   <= 1'b0;
      have_second_q <= 1'b0;
    end else if (clear) begin
      best_q        <= '0;
      second_q      <= '0;
      idx_q         <= '0;
      have_best_q   <= 1'b0;
      have_second_q <= 1'b0;
    end else if (update) begin
      best_q        <= best_d;
      second_q      <= second_d;
      idx_q         <= idx_d;
      have_best_q   <= have_best_d;
      have_second_q <= have_second_d;
    end
  end

  assign best        = best_q;
  assign second      = second_q;
  assign best_idx    = idx_q;
  assign have_second = have_second_q;

endmodule

// File: rtl/layer_dense_tiled.sv
// Dual-rail fully-connected classifier layer: buffers one input vector, computes class scores
// in tiles of LANES MACs, and returns argmax, its score and an early-exit flag.
module layer_dense_tiled
  import layer_dense_tiled_pkg::*;
#(
  parameter int unsigned BIT_DATA = 8,
  parameter int unsigned N_IN     = 128,
  parameter int unsigned N_OUT    = 10,
  parameter int unsigned LANES    = 4,
  parameter int unsigned BIT_ACC  = 32,
  parameter int unsigned BIT_SH   = $clog2(BIT_ACC - BIT_DATA),
  parameter int unsigned BIT_IDX  = $clog2(N_OUT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [$clog2(N_IN)-1:0]  waddr_in,
  input  logic [$clog2(N_OUT)-1:0] waddr_out,
  input  logic [BIT_DATA-1:0]      wt,
  input  logic [BIT_DATA-1:0]      wf,
  input  logic [BIT_DATA-1:0]      xt,
  input  logic [BIT_DATA-1:0]      xf,
  output logic                     ack_prev,
  input  logic                     ack_nxt,
  input  logic [BIT_SH-1:0]        scale,
  input  logic [BIT_DATA-1:0]      margin,
  output logic [BIT_DATA-1:0]      zt,
  output logic [BIT_DATA-1:0]      zf,
  output logic [BIT_IDX-1:0]       index_t,
  output logic [BIT_IDX-1:0]       index_f,
  output logic                     early
);

  localparam int unsigned NumTiles = ceil_div(N_OUT, LANES);
  localparam int unsigned BitAddr  = $clog2(N_IN);
  localparam int unsigned BitCls   = $clog2(N_OUT);
  localparam int unsigned BitCnt   = $clog2(N_IN + 1);
  localparam int unsigned BitTile  = (NumTiles > 1) ? $clog2(NumTiles) : 1;
  localparam int unsigned BitProd  = 2 * BIT_DATA;
  localparam logic signed [BIT_ACC-1:0] SatHi = BIT_ACC'(2 ** (BIT_DATA - 1) - 1);
  localparam logic signed [BIT_ACC-1:0] SatLo = ~SatHi;

  state_e                     state_q, state_d;
  logic [BitCnt-1:0]          cnt_q, cnt_d;
  logic [BitTile-1:0]         tile_q, tile_d;
  logic                       ack_q, ack_d;
  logic signed [BIT_ACC-1:0]  acc_q [LANES];
  logic signed [BIT_ACC-1:0]  acc_d [LANES];
  logic [BIT_DATA-1:0]        zt_q, zt_d, zf_q, zf_d;
  logic [BIT_IDX-1:0]         it_q, it_d, if_q, if_d;
  logic                       early_q, early_d;

  logic signed [BIT_DATA-1:0] xbuf  [N_IN];
  logic signed [BIT_DATA-1:0] w_mem [N_IN][N_OUT];

  logic x_code, x_spacer, w_code, load_ok, word_take, spacer_ack;
  logic last_word, tile_end, vec_start;
  logic [BitAddr-1:0] rd_idx;

  assign x_code     = (xt == ~xf);
  assign x_spacer   = (xt == '0) && (xf == '0);
  assign w_code     = (wt == ~wf);
  assign load_ok    = load && (state_q == StFill) && (cnt_q == '0) && !ack_q && w_code &&
                      (32'(waddr_out) < 32'(N_OUT));
  // A honoured load blocks input capture in the same cycle; the word stays un-acked.
  assign word_take  = (state_q == StFill) && x_code && !ack_q && !load_ok;
  assign spacer_ack = (state_q == StFill) && x_spacer && ack_q;
  assign last_word  = (cnt_q == BitCnt'(N_IN - 1));
  assign vec_start  = spacer_ack && last_word;
  assign tile_end   = (state_q == StCompute) && (cnt_q == BitCnt'(N_IN));
  assign rd_idx     = cnt_q[BitAddr-1:0];

  always_ff @(posedge clock) begin
    if (load_ok) w_mem[waddr_in][waddr_out] <= wt;
  end

  always_ff @(posedge clock) begin
    if (word_take) xbuf[rd_idx] <= xt;
  end

  // Per-lane datapath: weight fetch, MAC product, scaled and saturated score.
  logic [31:0]                base_col;
  logic [31:0]                col_w    [LANES];
  logic [LANES-1:0]           lane_valid;
  logic signed [BIT_DATA-1:0] w_lane   [LANES];
  logic signed [BitProd-1:0]  prod_w   [LANES];
  logic signed [BIT_ACC-1:0]  prod_ext [LANES];
  logic signed [BIT_ACC-1:0]  sh_w     [LANES];
  logic [LANES-1:0][BIT_DATA-1:0] score;

  always_comb begin
    base_col = 32'(tile_q) * 32'(LANES);
    for (int l = 0; l < LANES; l++) begin
      col_w[l]      = base_col + 32'(l);
      lane_valid[l] = (col_w[l] < 32'(N_OUT));
      w_lane[l]     = lane_valid[l] ? w_mem[rd_idx][col_w[l][BitCls-1:0]] : '0;
      prod_w[l]     = BitProd'(xbuf[rd_idx]) * BitProd'(w_lane[l]);
      prod_ext[l]   = BIT_ACC'(prod_w[l]);
      sh_w[l]       = acc_q[l] >>> scale;
      if (sh_w[l] > SatHi) begin
        score[l] = {1'b0, {(BIT_DATA - 1){1'b1}}};
      end else if (sh_w[l] < SatLo) begin
        score[l] = {1'b1, {(BIT_DATA - 1){1'b0}}};
      end else begin
        score[l] = sh_w[l][BIT_DATA-1:0];
      end
    end
  end

  logic signed [BIT_DATA-1:0] best, second;
  logic [BIT_IDX-1:0]         best_idx;
  logic                       have_second;
  logic signed [BIT_DATA:0]   diff;

  dense_top2 #(
    .BIT_DATA (BIT_DATA),
    .BIT_IDX  (BIT_IDX),
    .LANES    (LANES)
  ) u_top2 (
    .clock       (clock),
    .reset       (reset),
    .clear       (vec_start),
    .update      (tile_end),
    .base        (base_col[BIT_IDX-1:0]),
    .valid       (lane_valid),
    .scores      (score),
    .best        (best),
    .second      (second),
    .best_idx    (best_idx),
    .have_second (have_second)
  );

  assign diff = {best[BIT_DATA-1], best} - {second[BIT_DATA-1], second};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    ack_d   = ack_q;
    acc_d   = acc_q;
    zt_d    = zt_q;
    zf_d    = zf_q;
    it_d    = it_q;
    if_d    = if_q;
    early_d = early_q;
    unique case (state_q)
      StFill: begin
        if (word_take) begin
          ack_d = 1'b1;
        end else if (spacer_ack) begin
          ack_d = 1'b0;
          if (last_word) begin
            cnt_d   = '0;
            tile_d  = '0;
            acc_d   = '{default: '0};
            state_d = StCompute;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCompute: begin
        if (tile_end) begin
          acc_d = '{default: '0};
          cnt_d = '0;
          if (tile_q == BitTile'(NumTiles - 1)) state_d = StFinish;
          else tile_d = tile_q + 1'b1;
        end else begin
          for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l] + prod_ext[l];
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: begin
        zt_d    = best;
        zf_d    = ~best;
        it_d    = best_idx;
        if_d    = ~best_idx;
        // With a single class there is no runner-up, so exit is always allowed.
        early_d = !have_second || ($signed(diff) >= $signed({1'b0, margin}));
        state_d = StOut;
      end
      StOut: begin
        if (ack_nxt) begin
          zt_d    = '0;
          zf_d    = '0;
          it_d    = '0;
          if_d    = '0;
          early_d = 1'b0;
          state_d = StRtz;
        end
      end
      StRtz: begin
        if (!ack_nxt) begin
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFill;
      cnt_q   <= '0;
      tile_q  <= '0;
      ack_q   <= 1'b0;
      acc_q   <= '{default: '0};
      zt_q    <= '0;
      zf_q    <= '0;
      it_q    <= '0;
      if_q    <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      ack_q   <= ack_d;
      acc_q   <= acc_d;
      zt_q    <= zt_d;
      zf_q    <= zf_d;
      it_q    <= it_d;
      if_q    <= if_d;
      early_q <= early_d;
    end
  end

  assign ack_prev = ack_q;
  assign zt       = zt_q;
  assign zf       = zf_q;
  assign index_t  = it_q;
  assign index_f  = if_q;
  assign early    = early_q;

endmodule

// File: tb/tb_layer_dense_tiled.sv
// Scenario bench for layer_dense_tiled: a reference model pushes expected results to a
// scoreboard queue as vectors are sent, and they are popped when the output codeword appears.
module tb_layer_dense_tiled;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [6:0] waddr_in;
  logic [3:0] waddr_out;
  logic [7:0] wt, wf, xt, xf;
  logic       ack_prev;
  logic       ack_nxt;
  logic [4:0] scale;
  logic [7:0] margin;
  logic [7:0] zt, zf;
  logic [3:0] index_t, index_f;
  logic       early;

  always #5 clock = ~clock;

  layer_dense_tiled dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .waddr_in  (waddr_in),
    .waddr_out (waddr_out),
    .wt        (wt),
    .wf        (wf),
    .xt        (xt),
    .xf        (xf),
    .ack_prev  (ack_prev),
    .ack_nxt   (ack_nxt),
    .scale     (scale),
    .margin    (margin),
    .zt        (zt),
    .zf        (zf),
    .index_t   (index_t),
    .index_f   (index_f),
    .early     (early)
  );

  typedef struct packed {
    logic [7:0] z;
    logic [3:0] idx;
    logic       early;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic signed [7:0] wm [128][10];
  logic signed [7:0] xv [128];

  task automatic wait_ack(input logic level, input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (ack_prev === level) break;
    end
    checks++;
    if (ack_prev !== level) begin
      errors++;
      $display("FAIL %s: ack_prev=%b required %b", name, ack_prev, level);
    end
  endtask

  task automatic send_words(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clock);
      xt = xv[i];
      xf = ~xv[i];
      wait_ack(1'b1, "ack_rise");
      xt = '0;
      xf = '0;
      wait_ack(1'b0, "ack_fall");
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < 128; i++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        load      = 1'b1;
        waddr_in  = 7'(i);
        waddr_out = 4'(c);
        wt        = wm[i][c];
        wf        = ~wm[i][c];
      end
    end
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic clear_weights();
    for (int i = 0; i < 128; i++)
      for (int c = 0; c < 10; c++) wm[i][c] = '0;
  endtask

  // Reference: full dot products per class, shift, clamp, ascending-order top-2.
  task automatic push_expected(input int sc, input int mg);
    int   acc;
    int   s[10];
    int   b, sec, bi;
    bit   h2;
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      acc = 0;
      for (int i = 0; i < 128; i++) acc += int'(xv[i]) * int'(wm[i][c]);
      acc = acc >>> sc;
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
      s[c] = acc;
    end
    b = s[0]; bi = 0; sec = 0; h2 = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (s[c] > b) begin
        sec = b; h2 = 1'b1; b = s[c]; bi = c;
      end else if (!h2 || s[c] > sec) begin
        sec = s[c]; h2 = 1'b1;
      end
    end
    e.z     = 8'(b);
    e.idx   = 4'(bi);
    e.early = !h2 || ((b - sec) >= mg);
    sb.push_back(e);
  endtask

  task automatic drain_output(input string name);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clock);
      if (zt === ~zf) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_codeword: zt=%h zf=%h queued=%0d", name, zt, zf, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (zt !== e.z) begin
      errors++; $display("FAIL %s_zt: got %h required %h", name, zt, e.z);
    end
    checks++;
    if (index_t !== e.idx || index_f !== ~e.idx) begin
      errors++;
      $display("FAIL %s_index: got t=%h f=%h required t=%h", name, index_t, index_f, e.idx);
    end
    checks++;
    if (early !== e.early) begin
      errors++; $display("FAIL %s_early: got %b required %b", name, early, e.early);
    end
    ack_nxt = 1'b1;
    @(negedge clock);
    checks++;
    if ({zt, zf, index_t, index_f, early} !== 25'd0) begin
      errors++;
      $display("FAIL %s_spacer: zt=%h zf=%h it=%h if=%h early=%b", name, zt, zf, index_t,
               index_f, early);
    end
    ack_nxt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ack_prev !== 1'b0 || early !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ack_prev=%b early=%b required 0", ack_prev, early);
    end
    checks++;
    if ({zt, zf, index_t, index_f} !== 24'd0) begin
      errors++; $display("FAIL reset_out: zt=%h zf=%h it=%h if=%h required 0", zt, zf,
                         index_t, index_f);
    end
    reset = 1'b1;
    clear_weights();
    for (int i = 0; i < 128; i++) wm[i][7] = 8'sd1;
    load_all();
    for (int i = 0; i < 128; i++) xv[i] = 8'sd1;
    send_words(0, 50);
    @(negedge clock);
    xt = xv[50];
    xf = ~xv[50];
    wait_ack(1'b1, "mid_ack");
    reset = 1'b0;
    #1;
    checks++;
    if (ack_prev !== 1'b0 || early !== 1'b0 || {zt, zf, index_t, index_f} !== 24'd0) begin
      errors++; $display("FAIL midreset: ack_prev=%b early=%b zt=%h zf=%h required all 0",
                         ack_prev, early, zt, zf);
    end
    xt = '0;
    xf = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    scale  = 5'd0;
    margin = 8'd10;
    push_expected(0, 10);
    send_words(0, 128);
    drain_output("class7_sat");
  endtask

  task automatic test_tie();
    clear_weights();
    for (int i = 0; i < 128; i++) begin
      wm[i][3] = 8'sd1;
      wm[i][5] = 8'sd1;
    end
    load_all();
    scale  = 5'd2;
    margin = 8'd1;
    push_expected(2, 1);
    send_words(0, 128);
    drain_output("tie_low_index");
  endtask

  task automatic test_margin();
    clear_weights();
    for (int i = 0; i < 50; i++) wm[i][2] = 8'sd1;
    for (int i = 0; i < 45; i++) wm[i][8] = 8'sd1;
    load_all();
    scale  = 5'd0;
    margin = 8'd10;
    push_expected(0, 10);
    send_words(0, 128);
    drain_output("margin10");
    margin = 8'd5;
    push_expected(0, 5);
    send_words(0, 128);
    drain_output("margin5");
  endtask

  task automatic test_illegal_and_load();
    bit acked;
    acked = 1'b0;
    @(negedge clock);
    xt = 8'h01;
    xf = 8'h01;
    repeat (10) begin
      @(negedge clock);
      if (ack_prev !== 1'b0) acked = 1'b1;
    end
    checks++;
    if (acked) begin
      errors++; $display("FAIL illegal_word: ack_prev rose, required 0");
    end
    // Load and codeword together: the weight wins and the word waits.
    load      = 1'b1;
    waddr_in  = 7'd0;
    waddr_out = 4'd0;
    wt        = 8'd100;
    wf        = ~8'd100;
    xt        = 8'h01;
    xf        = 8'hfe;
    @(negedge clock);
    checks++;
    if (ack_prev !== 1'b0) begin
      errors++; $display("FAIL load_priority: ack_prev=%b required 0", ack_prev);
    end
    load = 1'b0;
    xt   = '0;
    xf   = '0;
    wm[0][0] = 8'sd100;
    scale  = 5'd0;
    margin = 8'd5;
    push_expected(0, 5);
    send_words(0, 128);
    // Now computing: these loads must be dropped.
    load      = 1'b1;
    waddr_in  = 7'd1;
    waddr_out = 4'd0;
    wt        = 8'd127;
    wf        = ~8'd127;
    repeat (5) @(negedge clock);
    load = 1'b0;
    drain_output("load_then_vec");
    push_expected(0, 5);
    send_words(0, 128);
    drain_output("compute_load_dropped");
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   seen, moved, acked;
    push_expected(0, 5);
    send_words(0, 128);
    seen = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clock);
      if (zt === ~zf) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL hold_codeword: zt=%h zf=%h", zt, zf);
    end
    e = sb.pop_front();
    xt = xv[0];
    xf = ~xv[0];
    moved = 1'b0;
    acked = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (zt !== e.z || zf !== ~e.z || index_t !== e.idx || early !== e.early) moved = 1'b1;
      if (ack_prev !== 1'b0) acked = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++; $display("FAIL hold_stable: zt=%h it=%h early=%b required %h %h %b", zt,
                         index_t, early, e.z, e.idx, e.early);
    end
    checks++;
    if (acked) begin
      errors++; $display("FAIL hold_no_ack: ack_prev rose during output, required 0");
    end
    ack_nxt = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (ack_prev !== 1'b0) acked = 1'b1;
    end
    checks++;
    if (acked || zt !== 8'd0 || zf !== 8'd0) begin
      errors++; $display("FAIL rtz_wait: ack_prev=%b zt=%h zf=%h required 0 0 0", ack_prev,
                         zt, zf);
    end
    ack_nxt = 1'b0;
    wait_ack(1'b1, "resume_ack");
    xt = '0;
    xf = '0;
    wait_ack(1'b0, "resume_fall");
    send_words(1, 127);
    push_expected(0, 5);
    drain_output("after_backpressure");
  endtask

  task automatic test_random();
    int sc, mg;
    for (int i = 0; i < 128; i++)
      for (int c = 0; c < 10; c++) wm[i][c] = 8'($urandom);
    load_all();
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 128; i++) xv[i] = 8'($urandom);
      sc = int'($urandom_range(4, 14));
      mg = int'($urandom_range(0, 60));
      scale  = 5'(sc);
      margin = 8'(mg);
      push_expected(sc, mg);
      send_words(0, 128);
      drain_output("random");
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load = 1'b0; waddr_in = '0; waddr_out = '0; wt = '0; wf = '0;
    xt = '0; xf = '0; ack_nxt = 1'b0; scale = '0; margin = '0;
    test_reset();
    test_tie();
    test_margin();
    test_illegal_and_load();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
